psum_accum_bank: RTL and testbench

Multi-channel, multi-slot partial-sum accumulator; the parametrised successor of the single-channel accumulator in the building-blocks library. It sums NUM_CH parallel psum lanes into DEPTH independently addressed accumulator slots per lane, with first/last framing, signed or unsigned arithmetic, and optional saturation. It sits between the PE array psum outputs and the output-feature-map writer, which it drives through a valid/ready output register.

---
 rtl/psum_accum_bank.sv | 181 ++++++++++++++++++
 tb/tb_psum_accum_bank.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accum_bank.sv
// psum_accum_bank
// Multi-lane, multi-slot partial-sum accumulator. Each accepted beat carries
// NUM_CH input lanes and a slot address. The beat is registered in S1. On the
// following edge it is added into slot[addr] for every lane: the slot value is
// replaced by zero when the beat is marked first. The sum can be signed or
// unsigned, and it either saturates or wraps. A beat marked last also loads
// the result into a valid/ready output register.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   in_valid_i   input beat valid
//   in_ready_o   bank can accept a beat this cycle (combinational on out_ready_i)
//   ipsum_i      NUM_CH input lanes, lane c = ipsum_i[c*IN_WIDTH +: IN_WIDTH]
//   in_addr_i    target slot
//   in_first_i   beat starts a new sum (slot contents ignored)
//   in_last_i    beat completes the sum, result is emitted
//   out_valid_o  result held in output register
//   out_ready_i  downstream accepts result
//   data_out_o   NUM_CH result lanes, lane c = data_out_o[c*ACC_WIDTH +: ACC_WIDTH]
//   out_addr_o   slot that produced the result
//   ovf_o        per-lane sticky overflow flag of the result
module psum_accum_bank #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 35,
  parameter int NUM_CH    = 4,
  parameter int DEPTH     = 8,
  parameter bit SIGNED    = 1'b1,
  parameter bit SATURATE  = 1'b1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [NUM_CH*IN_WIDTH-1:0]    ipsum_i,
  input  logic [AW-1:0]                 in_addr_i,
  input  logic                          in_first_i,
  input  logic                          in_last_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [NUM_CH*ACC_WIDTH-1:0]   data_out_o,
  output logic [AW-1:0]                 out_addr_o,
  output logic [NUM_CH-1:0]             ovf_o
);

  // One guard bit above the accumulator so that overflow is visible exactly.
  localparam int SW = ACC_WIDTH + 1;
  localparam int XW = SW - IN_WIDTH;

  logic                        s1_valid_q;
  logic [NUM_CH*IN_WIDTH-1:0]  s1_data_q;
  logic [AW-1:0]               s1_addr_q;
  logic                        s1_first_q;
  logic                        s1_last_q;

  logic [ACC_WIDTH-1:0]        slot_q [DEPTH][NUM_CH];
  logic [NUM_CH-1:0]           flag_q [DEPTH];

  logic                        out_valid_q;
  logic [NUM_CH*ACC_WIDTH-1:0] data_q;
  logic [AW-1:0]               out_addr_q;
  logic [NUM_CH-1:0]           ovf_q;

  logic                        stall;
  logic                        accept;
  logic                        commit;
  logic [ACC_WIDTH-1:0]        slot_d [NUM_CH];
  logic [NUM_CH-1:0]           flag_d;
  logic [NUM_CH-1:0]           lane_ovf;
  logic [NUM_CH*ACC_WIDTH-1:0] data_d;
  logic [IN_WIDTH-1:0]         lane_in;
  logic [ACC_WIDTH-1:0]        base;
  logic [SW-1:0]               base_x;
  logic [SW-1:0]               ext_x;
  logic [SW-1:0]               sum_x;
  logic [ACC_WIDTH-1:0]        sat_val;

  // Only a last beat can be blocked, and only by a result that has not been
  // taken yet. Non-last beats always commit.
  assign stall      = s1_valid_q && s1_last_q && out_valid_q && !out_ready_i;
  assign in_ready_o = !rst_i && !stall;
  assign accept     = in_valid_i && in_ready_o;
  assign commit     = s1_valid_q && !stall;

  always_comb begin
    lane_ovf = '0;
    data_d   = '0;
    lane_in  = '0;
    base     = '0;
    base_x   = '0;
    ext_x    = '0;
    sum_x    = '0;
    sat_val  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      slot_d[c] = '0;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      lane_in = s1_data_q[c*IN_WIDTH +: IN_WIDTH];
      base    = s1_first_q ? '0 : slot_q[s1_addr_q][c];
      if (SIGNED) begin
        ext_x  = {{XW{lane_in[IN_WIDTH-1]}}, lane_in};
        base_x = {base[ACC_WIDTH-1], base};
      end else begin
        ext_x  = {{XW{1'b0}}, lane_in};
        base_x = {1'b0, base};
      end
      sum_x = base_x + ext_x;
      if (SIGNED) begin
        // The top two bits differ only when the sum left the signed range.
        // The guard bit gives the direction of the overflow.
        lane_ovf[c] = sum_x[SW-1] ^ sum_x[SW-2];
        sat_val     = sum_x[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        lane_ovf[c] = sum_x[SW-1];
        sat_val     = '1;
      end
      slot_d[c] = (lane_ovf[c] && SATURATE) ? sat_val : sum_x[ACC_WIDTH-1:0];
      data_d[c*ACC_WIDTH +: ACC_WIDTH] = slot_d[c];
    end
    flag_d = s1_first_q ? lane_ovf : (flag_q[s1_addr_q] | lane_ovf);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_addr_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_data_q  <= ipsum_i;
        s1_addr_q  <= in_addr_i;
        s1_first_q <= in_first_i;
        s1_last_q  <= in_last_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int d = 0; d < DEPTH; d++) begin
        for (int c = 0; c < NUM_CH; c++) begin
          slot_q[d][c] <= '0;
        end
        flag_q[d] <= '0;
      end
    end else if (commit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        slot_q[s1_addr_q][c] <= slot_d[c];
      end
      flag_q[s1_addr_q] <= flag_d;
    end
  end

  // A new result can load on the same edge that the old one is taken.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      out_addr_q  <= '0;
      ovf_q       <= '0;
    end else if (commit && s1_last_q) begin
      out_valid_q <= 1'b1;
      data_q      <= data_d;
      out_addr_q  <= s1_addr_q;
      ovf_q       <= flag_d;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign data_out_o  = data_q;
  assign out_addr_o  = out_addr_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_psum_accum_bank.sv
// Testbench for psum_accum_bank with the default parameters (4 lanes, 8 slots,
// signed arithmetic, saturating). A reference model keeps every slot as a
// plain integer and predicts each emitted result. A negedge monitor compares
// every output handshake with the model. Table vectors and hand-written
// sequences also check against constants that are written out in the bench.
module tb_psum_accum_bank;

  localparam int IW  = 32;
  localparam int AWD = 35;
  localparam int NC  = 4;
  localparam int DP  = 8;
  localparam int AW  = 3;
  localparam longint ACC_MAX = (longint'(1) <<< (AWD-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (AWD-1));
  localparam int P32 = 32'sh7FFFFFFF;
  localparam int N32 = 32'sh80000000;

  typedef logic [NC-1:0][IW-1:0]  lanes_t;
  typedef logic [NC-1:0][AWD-1:0] accs_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          first;
    logic          last;
    lanes_t        lane;
    accs_t         exp;
    logic [NC-1:0] exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    accs_t         data;
    logic [NC-1:0] ovf;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NC*IW-1:0]  ipsum;
  logic [AW-1:0]     in_addr;
  logic              in_first;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [NC*AWD-1:0] data_out;
  logic [AW-1:0]     out_addr;
  logic [NC-1:0]     ovf;

  logic [1:0] ready_mode;   // 0: hold low, 1: hold high, 2: random
  logic       rnd_ready;
  assign out_ready = (ready_mode == 2'd2) ? rnd_ready : ready_mode[0];

  psum_accum_bank dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .ipsum_i    (ipsum),
    .in_addr_i  (in_addr),
    .in_first_i (in_first),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .data_out_o (data_out),
    .out_addr_o (out_addr),
    .ovf_o      (ovf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: slots are plain integers, clamped to the accumulator range.
  longint        m_slot [DP][NC];
  logic [NC-1:0] m_flag [DP];
  res_t          exp_q [$];
  res_t          obs_q [$];

  function automatic void model_reset();
    for (int d = 0; d < DP; d++) begin
      for (int c = 0; c < NC; c++) m_slot[d][c] = 0;
      m_flag[d] = '0;
    end
    exp_q.delete();
  endfunction

  function automatic void model_beat(input int a, input bit f, input bit l, input lanes_t ln);
    longint s;
    bit     ov;
    res_t   r;
    r.addr = a[AW-1:0];
    r.data = '0;
    for (int c = 0; c < NC; c++) begin
      s  = (f ? 64'sd0 : m_slot[a][c]) + longint'($signed(ln[c]));
      ov = (s > ACC_MAX) || (s < ACC_MIN);
      if (s > ACC_MAX) s = ACC_MAX;
      if (s < ACC_MIN) s = ACC_MIN;
      m_slot[a][c] = s;
      m_flag[a][c] = f ? ov : (m_flag[a][c] | ov);
      r.data[c] = s[AWD-1:0];
    end
    r.ovf = m_flag[a];
    if (l) exp_q.push_back(r);
  endfunction

  function automatic lanes_t lanes4(input int l0, input int l1, input int l2, input int l3);
    lanes_t r;
    r[0] = l0; r[1] = l1; r[2] = l2; r[3] = l3;
    return r;
  endfunction

  function automatic accs_t acc4(input longint e0, input longint e1, input longint e2, input longint e3);
    accs_t r;
    r[0] = e0[AWD-1:0]; r[1] = e1[AWD-1:0]; r[2] = e2[AWD-1:0]; r[3] = e3[AWD-1:0];
    return r;
  endfunction

  function automatic vec_t mk(input int a, input bit f, input bit l, input lanes_t ln,
                              input accs_t ex, input logic [NC-1:0] eo);
    vec_t v;
    v.addr = a[AW-1:0]; v.first = f; v.last = l; v.lane = ln; v.exp = ex; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call this right after a posedge. It presents the beat and waits for
  // acceptance. It returns just after the accepting edge.
  task automatic send_beat(input int a, input bit f, input bit l, input lanes_t ln, output int waited);
    bit ok;
    in_valid = 1'b1;
    in_addr  = a[AW-1:0];
    in_first = f;
    in_last  = l;
    ipsum    = ln;
    waited   = 0;
    ok       = 1'b0;
    while (!ok && waited <= 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waited++;
    end
    if (ok) begin
      model_beat(a, f, l, ln);
    end else begin
      n_checks++;
      $display("FAIL accept_timeout: slot %0d not accepted within %0d cycles", a, waited);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 9) < 7);
  end

  res_t mon_got;
  res_t mon_exp;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_got.addr = out_addr;
      mon_got.data = data_out;
      mon_got.ovf  = ovf;
      obs_q.push_back(mon_got);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: addr %0d data %h, no result expected", out_addr, data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("model_result", 160'(mon_got), 160'(mon_exp));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t   vecs [$];
  vec_t   v;
  int     w;
  int     lat;
  accs_t  res_a;
  lanes_t ln;
  logic [AWD-1:0] m12;

  initial begin
    rst = 1'b1; in_valid = 1'b0; ipsum = '0; in_addr = '0; in_first = 1'b0; in_last = 1'b0;
    ready_mode = 2'd1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_data", data_out, 0);
    chk("reset_addr", out_addr, 0);
    chk("reset_ovf", ovf, 0);
    step();
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    vecs.push_back(mk(3, 1, 0, lanes4(1, 2, 3, 4), '0, '0));
    vecs.push_back(mk(3, 0, 0, lanes4(10, 20, 30, 40), '0, '0));
    vecs.push_back(mk(3, 0, 1, lanes4(-5, -5, -5, -5), acc4(6, 17, 28, 39), 4'b0000));
    vecs.push_back(mk(2, 1, 0, lanes4(P32, N32, 1, 0), '0, '0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(2, 0, 0, lanes4(P32, N32, 1, 0), '0, '0));
    // Nine beats push lanes 0/1 past both bounds; the flag stays sticky after stepping back.
    vecs.push_back(mk(2, 0, 1, lanes4(-1, 1, 5, 0), acc4(ACC_MAX-1, ACC_MIN+1, 14, 0), 4'b0011));
    vecs.push_back(mk(2, 1, 0, lanes4(P32, P32, P32, P32), '0, '0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(2, 0, 0, lanes4(P32, P32, P32, P32), '0, '0));
    vecs.push_back(mk(2, 0, 1, lanes4(P32, P32, P32, P32),
                      acc4(64'sd10737418235, 64'sd10737418235, 64'sd10737418235, 64'sd10737418235), 4'b0000));
    vecs.push_back(mk(2, 1, 1, lanes4(5, 5, 5, 5), acc4(5, 5, 5, 5), 4'b0000));
    vecs.push_back(mk(1, 1, 1, lanes4(N32, P32, -1, 0), acc4(N32, P32, -1, 0), 4'b0000));
    vecs.push_back(mk(0, 1, 0, lanes4(100, 100, 100, 100), '0, '0));
    vecs.push_back(mk(0, 1, 1, lanes4(3, -3, 0, 7), acc4(3, -3, 0, 7), 4'b0000));
    vecs.push_back(mk(7, 0, 1, lanes4(4, -4, 0, 9), acc4(4, -4, 0, 9), 4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      send_beat(int'(v.addr), v.first, v.last, v.lane, w);
      if (v.last) begin
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (!out_valid && lat < 6);
        chk($sformatf("vec%0d_latency", i), lat, 2);
        chk($sformatf("vec%0d_data", i), data_out, v.exp);
        chk($sformatf("vec%0d_addr", i), out_addr, v.addr);
        chk($sformatf("vec%0d_ovf", i), ovf, v.exp_ovf);
        @(negedge clk);
        chk($sformatf("vec%0d_single_pulse", i), out_valid, 0);
        step();
      end
    end

    // ---------------- interleaved slots 0 / 1 ----------------
    obs_q.delete();
    for (int j = 0; j < 4; j++) begin
      send_beat(0, j == 0, j == 3, lanes4(7, 7, 7, 7), w);
      send_beat(1, j == 0, j == 3, lanes4(-3, -3, -3, -3), w);
    end
    repeat (4) @(negedge clk);
    chk("interleave_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      m12 = -12;
      chk("interleave_addr0", obs_q[0].addr, 0);
      chk("interleave_data0", obs_q[0].data, {4{35'd28}});
      chk("interleave_addr1", obs_q[1].addr, 1);
      chk("interleave_data1", obs_q[1].data, {4{m12}});
    end
    step();

    // ---------------- backpressure ----------------
    ready_mode = 2'd0;
    send_beat(4, 1, 1, lanes4(11, 12, 13, 14), w);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 6);
    res_a = acc4(11, 12, 13, 14);
    chk("bp_first_valid", out_valid, 1);
    step();
    send_beat(6, 1, 0, lanes4(50, 50, 50, 50), w);
    chk("bp_nonlast_no_stall", w, 0);
    send_beat(6, 0, 1, lanes4(7, 8, 9, 10), w);
    chk("bp_last_accept_wait", w, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_in_ready_low%0d", k), in_ready, 0);
      chk($sformatf("bp_held_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_held_data%0d", k), data_out, res_a);
      chk($sformatf("bp_held_addr%0d", k), out_addr, 4);
    end
    @(posedge clk);
    #1;
    ready_mode = 2'd1;
    @(negedge clk);
    chk("bp_in_ready_back", in_ready, 1);
    chk("bp_consume_data", data_out, res_a);
    @(negedge clk);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_data", data_out, acc4(57, 58, 59, 60));
    chk("bp_second_addr", out_addr, 6);
    chk("bp_second_ovf", ovf, 0);
    @(negedge clk);
    chk("bp_second_cleared", out_valid, 0);
    step();

    // ---------------- reset mid-sum ----------------
    ready_mode = 2'd0;
    send_beat(5, 1, 0, lanes4(100, 100, 100, 100), w);
    send_beat(5, 0, 0, lanes4(100, 100, 100, 100), w);
    send_beat(7, 1, 1, lanes4(9, 9, 9, 9), w);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 6);
    chk("rst_pending_valid", out_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    ready_mode = 2'd1;
    send_beat(5, 0, 1, lanes4(1, 1, 1, 1), w);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 6);
    chk("rst_after_data", data_out, acc4(1, 1, 1, 1));
    chk("rst_after_addr", out_addr, 5);
    chk("rst_after_ovf", ovf, 0);
    step();

    // ---------------- randomized traffic against the model ----------------
    ready_mode = 2'd2;
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NC; c++) begin
        case ($urandom_range(0, 5))
          0:       ln[c] = P32 - $urandom_range(0, 3);
          1:       ln[c] = N32 + $urandom_range(0, 3);
          2:       ln[c] = $urandom();
          default: ln[c] = $urandom_range(0, 2000) - 1000;
        endcase
      end
      send_beat($urandom_range(0, DP-1), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, ln, w);
      if ($urandom_range(0, 4) == 0) step();
    end
    ready_mode = 2'd1;
    lat = 0;
    while (exp_q.size() > 0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("random_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
